// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the MIPS instruction fetch unit: reset PC, FSM encoding,
// opcode constants used by the control unit, and the instruction-register payload.
package instr_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 6;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,
        FS_WAIT  = 2'd1,
        FS_HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;

    // Fetched instruction together with the address it came from
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, single-outstanding read FSM and instruction register
// feeding the decode stage. Redirects always win over sequential PC increment.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [XLEN-1:0]      imem_addr,
    input  logic [XLEN-1:0]      imem_rdata,
    input  logic                 imem_valid,
    input  logic                 redirect_valid,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [XLEN-1:0]      inst,
    output logic [OPW-1:0]       opcode,
    output logic [OPW-1:0]       funct,
    output logic [XLEN-1:0]      inst_pc,
    output logic [XLEN-1:0]      pc_plus4
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    fetch_entry_t    entry_q, entry_d;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] inst_c;

    assign redirect_target = word_align(redirect_pc);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FS_FETCH;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            entry_q <= entry_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        entry_d = entry_q;
        unique case (state_q)
            FS_FETCH: begin
                state_d = FS_WAIT;
                if (redirect_valid) begin
                    pc_d   = redirect_target;
                    drop_d = 1'b1;
                end
            end
            FS_WAIT: begin
                if (redirect_valid) begin
                    pc_d   = redirect_target;
                    drop_d = 1'b1;
                end
                // A return that coincides with a redirect is stale as well
                if (imem_valid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = FS_FETCH;
                    end else begin
                        entry_d = '{inst: imem_rdata, pc: pc_q};
                        state_d = FS_HOLD;
                    end
                end
            end
            FS_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = FS_FETCH;
                end else if (inst_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = FS_FETCH;
                end
            end
            default: state_d = FS_FETCH;
        endcase
    end

    // Outputs, all forced to zero while reset is asserted
    always_comb begin
        imem_req   = 1'b0;
        imem_addr  = '0;
        inst_valid = 1'b0;
        inst_c     = '0;
        inst_pc    = '0;
        pc_plus4   = '0;
        if (!reset) begin
            imem_req   = (state_q == FS_FETCH);
            imem_addr  = pc_q;
            inst_valid = (state_q == FS_HOLD);
            inst_c     = entry_q.inst;
            inst_pc    = entry_q.pc;
            pc_plus4   = entry_q.pc + XLEN'(4);
        end
    end

    assign inst   = inst_c;
    assign opcode = inst_c[31:26];
    assign funct  = inst_c[5:0];

endmodule
